bti_arb2: RTL and testbench

Two-master arbiter for the bus-transaction interface. It merges two `bus_trans_if_t` masters, such as instruction fetch and load/store, onto one downstream `bus_trans_if_t` slave, typically `bti_sram`. It allows one outstanding transaction at a time, remembers which master owns it, and routes the response back to that master only. Arbitration is round-robin by default; fixed priority is available at compile time.

---
 rtl/bti_arb2_if.sv | 25 ++
 rtl/bti_arb2.sv | 112 +++++++++++
 tb/tb_bti_arb2.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bti_arb2_if.sv
// Bus-transaction interface: one request channel and one response channel, each valid/ready.
interface bus_trans_if_t #(
    parameter int AW = 32,
    parameter int DW = 32
);
    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
    } req_pkt_t;

    typedef struct packed {
        logic [DW-1:0] data;
    } rsp_pkt_t;

    logic     req_vld;
    logic     req_rdy;
    req_pkt_t req_pkt;
    logic     rsp_vld;
    logic     rsp_rdy;
    rsp_pkt_t rsp_pkt;

    modport master (output req_vld, req_pkt, rsp_rdy, input req_rdy, rsp_vld, rsp_pkt);
    modport slave  (input req_vld, req_pkt, rsp_rdy, output req_rdy, rsp_vld, rsp_pkt);
endinterface

// File: rtl/bti_arb2.sv
// Two-master bus-transaction arbiter with one outstanding transaction and owner-routed responses.
// Define BTI_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins); default is round-robin.
module bti_arb2 #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic            clk,
    input logic            rst_n,
    bus_trans_if_t.slave   bti_m0,
    bus_trans_if_t.slave   bti_m1,
    bus_trans_if_t.master  bti_s
);
    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_gnt;
    logic          w_gnt_nxt;
    logic          w_pref;
    logic          w_any;
    logic          w_sel;
    logic          w_own;
    logic          w_own_req_vld;
    logic          w_s_req_vld;
    logic          w_req_hs;
    logic          w_own_rsp_rdy;
    logic          w_rsp_hs;
    logic [AW-1:0] w_req_addr;
    logic          w_req_wen;
    logic [DW-1:0] w_req_wdata;
    logic [DW-1:0] w_rsp_data;

`ifdef BTI_ARB_FIXED_PRIO_EN
    assign w_pref = 1'b0;
`else
    logic r_rr_ptr;

    // After a completed transaction the other master becomes preferred.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (w_rsp_hs) begin
            r_rr_ptr <= ~r_gnt;
        end
    end

    assign w_pref = r_rr_ptr;
`endif

    assign w_any = bti_m0.req_vld | bti_m1.req_vld;
    assign w_sel = (bti_m0.req_vld & bti_m1.req_vld) ? w_pref : bti_m1.req_vld;
    assign w_own = (r_state == IDLE) ? w_sel : r_gnt;

    assign w_own_req_vld = w_own ? bti_m1.req_vld : bti_m0.req_vld;
    assign w_s_req_vld   = (r_state != RSP) & w_own_req_vld;
    assign w_req_hs      = w_s_req_vld & bti_s.req_rdy;

    assign w_req_addr  = w_own ? bti_m1.req_pkt.addr  : bti_m0.req_pkt.addr;
    assign w_req_wen   = w_own ? bti_m1.req_pkt.wen   : bti_m0.req_pkt.wen;
    assign w_req_wdata = w_own ? bti_m1.req_pkt.wdata : bti_m0.req_pkt.wdata;

    assign bti_s.req_vld       = w_s_req_vld;
    assign bti_s.req_pkt.addr  = w_req_addr;
    assign bti_s.req_pkt.wen   = w_req_wen;
    assign bti_s.req_pkt.wdata = w_req_wdata;
    assign bti_m0.req_rdy      = w_req_hs & ~w_own;
    assign bti_m1.req_rdy      = w_req_hs & w_own;

    // Response data is broadcast; only the owner ever sees rsp_vld.
    assign w_own_rsp_rdy        = r_gnt ? bti_m1.rsp_rdy : bti_m0.rsp_rdy;
    assign w_rsp_hs             = (r_state == RSP) & bti_s.rsp_vld & w_own_rsp_rdy;
    assign bti_s.rsp_rdy        = (r_state == RSP) & w_own_rsp_rdy;
    assign bti_m0.rsp_vld       = (r_state == RSP) & ~r_gnt & bti_s.rsp_vld;
    assign bti_m1.rsp_vld       = (r_state == RSP) & r_gnt & bti_s.rsp_vld;
    assign w_rsp_data           = bti_s.rsp_pkt.data;
    assign bti_m0.rsp_pkt.data  = w_rsp_data;
    assign bti_m1.rsp_pkt.data  = w_rsp_data;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_gnt_nxt   = w_sel;
                    w_state_nxt = w_req_hs ? RSP : REQ;
                end
            end
            REQ: begin
                if (w_req_hs) begin
                    w_state_nxt = RSP;
                end
            end
            RSP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end
endmodule

// File: tb/tb_bti_arb2.sv
// Self-checking bench for bti_arb2: directed scenarios plus a randomized run against a transaction-level model.
module tb_bti_arb2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bus_trans_if_t #(.AW(32), .DW(32)) m0_if ();
    bus_trans_if_t #(.AW(32), .DW(32)) m1_if ();
    bus_trans_if_t #(.AW(32), .DW(32)) s_if ();

    bti_arb2 #(.AW(32), .DW(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bti_m0 (m0_if),
        .bti_m1 (m1_if),
        .bti_s  (s_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_if.req_vld = 1'b0; m0_if.req_pkt = '0; m0_if.rsp_rdy = 1'b0;
        m1_if.req_vld = 1'b0; m1_if.req_pkt = '0; m1_if.rsp_rdy = 1'b0;
        s_if.req_rdy  = 1'b0; s_if.rsp_vld  = 1'b0; s_if.rsp_pkt = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++; if (s_if.req_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_req_vld: got %b want 0", s_if.req_vld); end
        checks++; if ({m0_if.req_rdy, m1_if.req_rdy} !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_rdy: got %b want 00", {m0_if.req_rdy, m1_if.req_rdy}); end
        checks++; if ({m0_if.rsp_vld, m1_if.rsp_vld} !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_vld: got %b want 00", {m0_if.rsp_vld, m1_if.rsp_vld}); end
        rst_n = 1'b1;
        tick();
        s_if.rsp_vld = 1'b1;
        m0_if.rsp_rdy = 1'b1;
        @(negedge clk);
        checks++; if ({m0_if.rsp_vld, m1_if.rsp_vld} !== 2'b00) begin errors++; $display("[TB] FAIL idle_rsp_vld_gated: got %b want 00", {m0_if.rsp_vld, m1_if.rsp_vld}); end
        checks++; if (s_if.rsp_rdy !== 1'b0) begin errors++; $display("[TB] FAIL idle_s_rsp_rdy: got %b want 0", s_if.rsp_rdy); end
        tick();
        clear_inputs();
    endtask

    task automatic test_single();
        m0_if.req_vld = 1'b1; m0_if.req_pkt.addr = 32'h0000_0010;
        s_if.req_rdy = 1'b1; m0_if.rsp_rdy = 1'b1; m1_if.rsp_rdy = 1'b1;
        @(negedge clk);
        checks++; if (s_if.req_vld !== 1'b1) begin errors++; $display("[TB] FAIL single_s_req_vld: got %b want 1", s_if.req_vld); end
        checks++; if (s_if.req_pkt.addr !== 32'h10) begin errors++; $display("[TB] FAIL single_addr: got %h want 00000010", s_if.req_pkt.addr); end
        checks++; if ({m0_if.req_rdy, m1_if.req_rdy} !== 2'b10) begin errors++; $display("[TB] FAIL single_req_rdy: got %b want 10", {m0_if.req_rdy, m1_if.req_rdy}); end
        tick();
        m0_if.req_vld = 1'b0;
        s_if.rsp_vld = 1'b1; s_if.rsp_pkt.data = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (m0_if.rsp_vld !== 1'b1) begin errors++; $display("[TB] FAIL single_m0_rsp_vld: got %b want 1", m0_if.rsp_vld); end
        checks++; if (m0_if.rsp_pkt.data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL single_data: got %h want deadbeef", m0_if.rsp_pkt.data); end
        checks++; if (m1_if.rsp_vld !== 1'b0) begin errors++; $display("[TB] FAIL single_m1_rsp_vld: got %b want 0", m1_if.rsp_vld); end
        checks++; if (s_if.rsp_rdy !== 1'b1) begin errors++; $display("[TB] FAIL single_s_rsp_rdy: got %b want 1", s_if.rsp_rdy); end
        checks++; if (s_if.req_vld !== 1'b0) begin errors++; $display("[TB] FAIL single_rsp_no_req: got %b want 0", s_if.req_vld); end
        tick();
        s_if.rsp_vld = 1'b0;
        @(negedge clk);
        checks++; if ({m0_if.rsp_vld, m1_if.rsp_vld} !== 2'b00) begin errors++; $display("[TB] FAIL single_done: got %b want 00", {m0_if.rsp_vld, m1_if.rsp_vld}); end
        tick();
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        logic g;
        do_reset();
        m0_if.req_vld = 1'b1; m0_if.req_pkt.addr = 32'h100;
        m1_if.req_vld = 1'b1; m1_if.req_pkt.addr = 32'h200;
        s_if.req_rdy = 1'b1; m0_if.rsp_rdy = 1'b1; m1_if.rsp_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
`ifdef BTI_ARB_FIXED_PRIO_EN
            g = 1'b0;
`else
            g = (k % 2 == 1);
`endif
            @(negedge clk);
            checks++; if (s_if.req_pkt.addr !== (g ? 32'h200 : 32'h100)) begin errors++; $display("[TB] FAIL sim_grant_addr k=%0d: got %h want %h", k, s_if.req_pkt.addr, g ? 32'h200 : 32'h100); end
            checks++; if ({m0_if.req_rdy, m1_if.req_rdy} !== (g ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL sim_req_rdy k=%0d: got %b want %b", k, {m0_if.req_rdy, m1_if.req_rdy}, g ? 2'b01 : 2'b10); end
            tick();
            s_if.rsp_vld = 1'b1; s_if.rsp_pkt.data = 32'h1000 + k;
            @(negedge clk);
            checks++; if ({m0_if.rsp_vld, m1_if.rsp_vld} !== (g ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL sim_rsp_route k=%0d: got %b want %b", k, {m0_if.rsp_vld, m1_if.rsp_vld}, g ? 2'b01 : 2'b10); end
            checks++; if ({s_if.req_vld, m0_if.req_rdy, m1_if.req_rdy} !== 3'b000) begin errors++; $display("[TB] FAIL sim_rsp_blocks_req k=%0d: got %b want 000", k, {s_if.req_vld, m0_if.req_rdy, m1_if.req_rdy}); end
            tick();
            s_if.rsp_vld = 1'b0;
        end
        m0_if.req_vld = 1'b0;
        @(negedge clk);
        checks++; if (s_if.req_pkt.addr !== 32'h200) begin errors++; $display("[TB] FAIL sim_m1_alone: got %h want 00000200", s_if.req_pkt.addr); end
        checks++; if (m1_if.req_rdy !== 1'b1) begin errors++; $display("[TB] FAIL sim_m1_rdy: got %b want 1", m1_if.req_rdy); end
        tick();
        m1_if.req_vld = 1'b0;
        s_if.rsp_vld = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        m1_if.req_vld = 1'b1; m1_if.req_pkt.addr = 32'h300;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (s_if.req_pkt.addr !== 32'h300) begin errors++; $display("[TB] FAIL stall_addr c=%0d: got %h want 00000300", c, s_if.req_pkt.addr); end
            checks++; if ({s_if.req_vld, m0_if.req_rdy, m1_if.req_rdy} !== 3'b100) begin errors++; $display("[TB] FAIL stall_hs c=%0d: got %b want 100", c, {s_if.req_vld, m0_if.req_rdy, m1_if.req_rdy}); end
            tick();
            if (c == 0) begin
                m0_if.req_vld = 1'b1; m0_if.req_pkt.addr = 32'h400;
            end
        end
        s_if.req_rdy = 1'b1;
        @(negedge clk);
        checks++; if (s_if.req_pkt.addr !== 32'h300) begin errors++; $display("[TB] FAIL stall_release_addr: got %h want 00000300", s_if.req_pkt.addr); end
        checks++; if ({m0_if.req_rdy, m1_if.req_rdy} !== 2'b01) begin errors++; $display("[TB] FAIL stall_release_rdy: got %b want 01", {m0_if.req_rdy, m1_if.req_rdy}); end
        tick();
        m1_if.req_vld = 1'b0;
    endtask

    task automatic test_rsp_backpressure();
        s_if.rsp_vld = 1'b1; s_if.rsp_pkt.data = 32'h33;
        m1_if.rsp_rdy = 1'b0; m0_if.rsp_rdy = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (s_if.rsp_rdy !== 1'b0) begin errors++; $display("[TB] FAIL bp_s_rsp_rdy c=%0d: got %b want 0", c, s_if.rsp_rdy); end
            checks++; if ({m0_if.rsp_vld, m1_if.rsp_vld} !== 2'b01) begin errors++; $display("[TB] FAIL bp_rsp_vld c=%0d: got %b want 01", c, {m0_if.rsp_vld, m1_if.rsp_vld}); end
            checks++; if ({s_if.req_vld, m0_if.req_rdy} !== 2'b00) begin errors++; $display("[TB] FAIL bp_other_blocked c=%0d: got %b want 00", c, {s_if.req_vld, m0_if.req_rdy}); end
            tick();
        end
        m1_if.rsp_rdy = 1'b1;
        @(negedge clk);
        checks++; if (s_if.rsp_rdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_release: got %b want 1", s_if.rsp_rdy); end
        checks++; if (m1_if.rsp_pkt.data !== 32'h33) begin errors++; $display("[TB] FAIL bp_data: got %h want 00000033", m1_if.rsp_pkt.data); end
        tick();
        s_if.rsp_vld = 1'b0;
        @(negedge clk);
        checks++; if (s_if.req_pkt.addr !== 32'h400 || m0_if.req_rdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_next_m0: got addr %h rdy %b want 00000400 1", s_if.req_pkt.addr, m0_if.req_rdy); end
        tick();
        m0_if.req_vld = 1'b0;
        s_if.rsp_vld = 1'b1;
        tick();
        s_if.rsp_vld = 1'b0;
    endtask

    task automatic test_reset_mid_rsp();
        m0_if.req_vld = 1'b1; m0_if.req_pkt.addr = 32'h500;
        @(negedge clk);
        checks++; if (m0_if.req_rdy !== 1'b1) begin errors++; $display("[TB] FAIL rmr_issue: got %b want 1", m0_if.req_rdy); end
        tick();
        m0_if.req_vld = 1'b0; m0_if.rsp_rdy = 1'b0;
        s_if.rsp_vld = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m0_if.rsp_rdy = 1'b1;
        @(negedge clk);
        checks++; if ({m0_if.rsp_vld, m1_if.rsp_vld} !== 2'b00) begin errors++; $display("[TB] FAIL rmr_rsp_vld: got %b want 00", {m0_if.rsp_vld, m1_if.rsp_vld}); end
        checks++; if (s_if.rsp_rdy !== 1'b0) begin errors++; $display("[TB] FAIL rmr_idle: got %b want 0", s_if.rsp_rdy); end
        tick();
        s_if.rsp_vld = 1'b0;
        m0_if.req_vld = 1'b1; m0_if.req_pkt.addr = 32'h600;
        m1_if.req_vld = 1'b1; m1_if.req_pkt.addr = 32'h700;
        @(negedge clk);
        checks++; if (s_if.req_pkt.addr !== 32'h600 || {m0_if.req_rdy, m1_if.req_rdy} !== 2'b10) begin errors++; $display("[TB] FAIL rmr_rr_ptr_cleared: got addr %h rdy %b want 00000600 10", s_if.req_pkt.addr, {m0_if.req_rdy, m1_if.req_rdy}); end
        tick();
        clear_inputs();
    endtask

    // Transaction-level model: who owns the bus, whether the request was accepted, who was served last.
    task automatic test_random();
        logic        vld[2];
        logic [31:0] addr[2];
        logic [31:0] issued[2];
        logic        rrdy[2];
        logic        srdy, srv, spend, acc, any, req_hs, rsp_hs;
        logic [31:0] saddr;
        logic        e_svld, e_rdy0, e_rdy1, e_rv0, e_rv1, e_srr;
        logic [31:0] got_data;
        int          own, last, cand, pref;
        do_reset();
        vld[0] = 1'b0; vld[1] = 1'b0; addr[0] = '0; addr[1] = '0;
        issued[0] = '0; issued[1] = '0;
        own = -1; last = -1; acc = 1'b0; srv = 1'b0; spend = 1'b0; saddr = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!vld[i] && $urandom_range(0, 1) == 1) begin
                    vld[i] = 1'b1;
                    addr[i] = $urandom;
                end
                rrdy[i] = ($urandom_range(0, 9) < 7);
            end
            srdy = ($urandom_range(0, 9) < 6);
            if (spend && !srv) srv = ($urandom_range(0, 1) == 1);
            m0_if.req_vld = vld[0]; m0_if.req_pkt.addr = addr[0]; m0_if.rsp_rdy = rrdy[0];
            m1_if.req_vld = vld[1]; m1_if.req_pkt.addr = addr[1]; m1_if.rsp_rdy = rrdy[1];
            s_if.req_rdy = srdy; s_if.rsp_vld = srv; s_if.rsp_pkt.data = saddr ^ 32'hA5A5_5A5A;
`ifdef BTI_ARB_FIXED_PRIO_EN
            pref = 0;
`else
            pref = (last == 0) ? 1 : 0;
`endif
            if (own >= 0) cand = own;
            else if (vld[0] && vld[1]) cand = pref;
            else cand = vld[1] ? 1 : 0;
            any = (own >= 0) ? 1'b1 : (vld[0] | vld[1]);
            if (own >= 0 && acc) begin
                e_svld = 1'b0; e_rdy0 = 1'b0; e_rdy1 = 1'b0;
                e_rv0 = (own == 0) && srv; e_rv1 = (own == 1) && srv; e_srr = rrdy[own];
            end else begin
                e_svld = any; e_rdy0 = any && srdy && cand == 0; e_rdy1 = any && srdy && cand == 1;
                e_rv0 = 1'b0; e_rv1 = 1'b0; e_srr = 1'b0;
            end
            req_hs = !(own >= 0 && acc) && any && srdy;
            rsp_hs = (own >= 0) && acc && srv && rrdy[own];
            @(negedge clk);
            checks++; if (s_if.req_vld !== e_svld) begin errors++; $display("[TB] FAIL rand_s_req_vld cyc=%0d: got %b want %b", cyc, s_if.req_vld, e_svld); end
            checks++; if ({m0_if.req_rdy, m1_if.req_rdy} !== {e_rdy0, e_rdy1}) begin errors++; $display("[TB] FAIL rand_req_rdy cyc=%0d: got %b want %b", cyc, {m0_if.req_rdy, m1_if.req_rdy}, {e_rdy0, e_rdy1}); end
            checks++; if ({m0_if.rsp_vld, m1_if.rsp_vld} !== {e_rv0, e_rv1}) begin errors++; $display("[TB] FAIL rand_rsp_vld cyc=%0d: got %b want %b", cyc, {m0_if.rsp_vld, m1_if.rsp_vld}, {e_rv0, e_rv1}); end
            checks++; if (s_if.rsp_rdy !== e_srr) begin errors++; $display("[TB] FAIL rand_s_rsp_rdy cyc=%0d: got %b want %b", cyc, s_if.rsp_rdy, e_srr); end
            if (e_svld) begin
                checks++; if (s_if.req_pkt.addr !== addr[cand]) begin errors++; $display("[TB] FAIL rand_addr cyc=%0d: got %h want %h", cyc, s_if.req_pkt.addr, addr[cand]); end
            end
            if (rsp_hs) begin
                got_data = (own == 1) ? m1_if.rsp_pkt.data : m0_if.rsp_pkt.data;
                checks++; if (got_data !== (issued[own] ^ 32'hA5A5_5A5A)) begin errors++; $display("[TB] FAIL rand_rsp_data cyc=%0d: got %h want %h", cyc, got_data, issued[own] ^ 32'hA5A5_5A5A); end
            end
            tick();
            if (own < 0 && any) own = cand;
            if (req_hs) begin
                acc = 1'b1;
                vld[cand] = 1'b0;
                issued[cand] = addr[cand];
                spend = 1'b1;
                saddr = addr[cand];
            end
            if (rsp_hs) begin
                last = own;
                own = -1;
                acc = 1'b0;
                spend = 1'b0;
                srv = 1'b0;
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_simultaneous();
        test_stall();
        test_rsp_backpressure();
        test_reset_mid_rsp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
